// File: rtl/sta_output_writer.sv
// Output stage after sta_controller: saturates each int32 pixel to int8, computes its byte address,
// buffers it in a FIFO and drains the FIFO into activation memory over a req/ack write port.
module sta_output_writer #(
    parameter  int MAX_N       = 512,
    parameter  int FIFO_DEPTH  = 16,
    parameter  int ADDR_W      = 18,
    localparam int CTRL_N_BITS = $clog2(MAX_N + 1),
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [CTRL_N_BITS-1:0] mat_size,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   in_valid,
    input  logic signed [31:0]     in_data,
    input  logic [CTRL_N_BITS-1:0] in_row,
    input  logic [CTRL_N_BITS-1:0] in_col,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [7:0]             mem_wdata,
    input  logic                   mem_ack,
    input  logic                   flag_clr,
    output logic [CNT_W-1:0]       fifo_count,
    output logic                   busy,
    output logic                   overflow,
    output logic                   range_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]        addr_mem [FIFO_DEPTH];
    logic [7:0]               data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         rd_ptr_nxt;
    logic [PTR_W-1:0]         load_ptr;
    logic [2*CTRL_N_BITS-1:0] prod;
    logic [ADDR_W-1:0]        push_addr;
    logic [7:0]               push_data;
    logic                     in_range;
    logic                     full;
    logic                     pop;
    logic                     push;
    logic                     drop_full;
    logic                     drop_range;
    logic                     load;

    always_comb begin
        prod       = {{CTRL_N_BITS{1'b0}}, in_row} * {{CTRL_N_BITS{1'b0}}, mat_size};
        push_addr  = base_addr + ADDR_W'(prod) + ADDR_W'(in_col);
        if (in_data > 32'sd127)
            push_data = 8'h7f;
        else if (in_data < -32'sd128)
            push_data = 8'h80;
        else
            push_data = in_data[7:0];

        in_range   = (in_row < mat_size) && (in_col < mat_size);
        full       = (fifo_count == CNT_W'(FIFO_DEPTH));
        pop        = (state == REQ) && mem_ack;
        push       = in_valid && in_range && (!full || pop);
        drop_full  = in_valid && in_range && full && !pop;
        drop_range = in_valid && !in_range;
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
        mem_req    = (state == REQ);
        busy       = (fifo_count != '0) || mem_req;
    end

    // The head stays in the FIFO until acked; on an ack the next entry is rd_ptr+1.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_ptr  = rd_ptr;
        case (state)
            IDLE: begin
                if ((fifo_count != '0) && !stall) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if ((fifo_count > CNT_W'(1)) && !stall) begin
                        load     = 1'b1;
                        load_ptr = rd_ptr_nxt;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            overflow   <= 1'b0;
            range_err  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (load) begin
                mem_addr  <= addr_mem[load_ptr];
                mem_wdata <= data_mem[load_ptr];
            end
            if (drop_full)
                overflow <= 1'b1;
            else if (flag_clr)
                overflow <= 1'b0;
            if (drop_range)
                range_err <= 1'b1;
            else if (flag_clr)
                range_err <= 1'b0;
        end
    end

endmodule
